// File: rtl/frame_decoder_pkg.sv
// Shared readout definitions: stream markers, field widths, decoder states,
// the payload FIFO entry layout and the ROI peel-order priority encoder.
// Ports: none (package).
package readout_pkg;

    localparam int DATA_W = 30;   // readout stream word
    localparam int BCID_W = 12;   // L1ACC/BCID field of the SOF word
    localparam int ROI_W  = 16;   // one bit per pixel of the 4x4 matrix
    localparam int PIX_W  = 4;    // pixel index 0..15
    localparam int WIDX_W = 8;    // word index as carried on the output bus

    // SOF is recognised on the upper 18 bits only; the low 12 bits carry BCID.
    localparam logic [17:0]       SOF_MARK  = 18'h25555;
    localparam logic [DATA_W-1:0] EOF_WORD  = 30'h2EADBEEF;
    localparam logic [DATA_W-1:0] IDLE_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_TRAILER = 2'd2
    } state_t;

    // One payload FIFO entry, packed MSB-first as {last, pix, widx, data}.
    typedef struct packed {
        logic              last;
        logic [PIX_W-1:0]  pix;
        logic [WIDX_W-1:0] widx;
        logic [DATA_W-1:0] data;
    } pay_t;

    // Index of the highest set bit of the mask (0 when the mask is empty).
    // The sequencer reads pixels out in this same highest-first order, so
    // both sides must use this one function.
    function automatic logic [PIX_W-1:0] prio_enc(input logic [ROI_W-1:0] mask);
        logic [PIX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ROI_W; i++) begin
            if (mask[i]) idx = PIX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/frame_decoder_if.sv
// Bus bundle between the readout stream source / payload consumer and the
// frame decoder. master = stream source + consumer side, slave = decoder.
// Signals: din/roi stream inputs, rd_* FWFT payload port, frame_* status.
interface frame_decoder_if;
    import readout_pkg::*;

    logic [DATA_W-1:0] din;
    logic [ROI_W-1:0]  roi;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [PIX_W-1:0]  rd_pix;
    logic [WIDX_W-1:0] rd_widx;
    logic              rd_last;
    logic [BCID_W-1:0] frame_l1id;
    logic              frame_done;
    logic [1:0]        frame_err;
    logic              busy;
    logic [15:0]       frame_cnt;
    logic [7:0]        err_cnt;

    modport master (
        output din, roi, rd_ready,
        input  rd_valid, rd_data, rd_pix, rd_widx, rd_last,
        input  frame_l1id, frame_done, frame_err, busy, frame_cnt, err_cnt
    );

    modport slave (
        input  din, roi, rd_ready,
        output rd_valid, rd_data, rd_pix, rd_widx, rd_last,
        output frame_l1id, frame_done, frame_err, busy, frame_cnt, err_cnt
    );

endinterface

// File: rtl/frame_decoder_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags.
// Latency: a push at edge N is visible on o_head_dat right after edge N.
// Backpressure: a push while full is accepted only if a pop happens in the
// same cycle; otherwise it is ignored (the caller detects the drop).
// Ports: clk/rst, i_push/i_push_dat write side, i_pop read side,
//        o_head_dat current head, o_full/o_empty occupancy flags.
module frame_fifo #(
    parameter int W     = 43,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_head_dat,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

    // Full + pop frees the slot being written, so that push still lands.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_head_dat = r_mem[r_rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    // Storage needs no reset: nothing reads it while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/frame_decoder.sv
// Receive-side ETROC1 frame decoder: locks on SOF, tags payload words with
// pixel/word index into a FWFT FIFO, checks the EOF trailer and counts frames.
// Latency: payload word sampled at edge N is on rd_* after N; frame_done
// pulses the cycle after the trailer edge. Backpressure: the stream cannot be
// stalled; pushes into a full FIFO are dropped and flagged as overflow.
// Ports: clock/reset; bus (slave): din/roi stream in, rd_* payload out,
//        frame_l1id/frame_done/frame_err/busy/frame_cnt/err_cnt status.
module frame_decoder
    import readout_pkg::*;
#(
    parameter int FIFO_DEPTH           = 16,
    parameter int WORDS_PER_PIXEL_LOG2 = 8
) (
    input  logic            clock,
    input  logic            reset,
    frame_decoder_if.slave  bus
);
    localparam int WW = WORDS_PER_PIXEL_LOG2;

    state_t r_state;
    state_t w_next_state;

    logic [ROI_W-1:0]  r_roi;        // pixels still to be read in this frame
    logic [WW-1:0]     r_widx;       // word index within current pixel buffer
    logic [BCID_W-1:0] r_l1id;
    logic [1:0]        r_err;        // per-frame sticky: bit1 = overflow
    logic              r_done;
    logic [1:0]        r_frame_err;
    logic [15:0]       r_frame_cnt;
    logic [7:0]        r_err_cnt;

    logic              w_is_sof;
    logic [PIX_W-1:0]  w_pix;
    logic              w_single;
    logic              w_widx_end;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;
    logic [1:0]        w_trl_err;
    pay_t              w_push_ent;
    pay_t              w_head;

    assign w_is_sof   = (bus.din[DATA_W-1:BCID_W] == SOF_MARK);
    assign w_pix      = prio_enc(r_roi);
    // Exactly one pixel left: clearing the lowest set bit leaves nothing.
    assign w_single   = ((r_roi & (r_roi - ROI_W'(1))) == '0);
    assign w_widx_end = (r_widx == '1);
    assign w_trl_err  = {r_err[1], (bus.din != EOF_WORD)};

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Only SOF matters here; stray EOF or noise is ignored.
                if (w_is_sof) begin
                    w_next_state = (bus.roi == '0) ? ST_TRAILER : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                // Payload is never pattern-matched: it may alias SOF/EOF.
                w_push = 1'b1;
                if (w_widx_end && w_single) w_next_state = ST_TRAILER;
            end
            ST_TRAILER: begin
                // The trailer slot is consumed here and never retried as SOF.
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Payload FIFO
    // ---------------------------------------------------------------
    always_comb begin
        w_push_ent      = '0;
        w_push_ent.last = w_widx_end & w_single;
        w_push_ent.pix  = w_pix;
        w_push_ent.widx = WIDX_W'(r_widx);
        w_push_ent.data = bus.din;
    end

    assign w_pop  = bus.rd_ready & ~w_empty;
    assign w_drop = w_push & w_full & ~w_pop;

    frame_fifo #(
        .W     ($bits(pay_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clock),
        .rst        (reset),
        .i_push     (w_push),
        .i_push_dat (w_push_ent),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // ---------------------------------------------------------------
    // Frame bookkeeping
    // ---------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_roi       <= '0;
            r_widx      <= '0;
            r_l1id      <= '0;
            r_err       <= '0;
            r_done      <= 1'b0;
            r_frame_err <= '0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_done      <= 1'b0;
            r_frame_err <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_is_sof) begin
                        r_l1id <= bus.din[BCID_W-1:0];
                        r_roi  <= bus.roi;
                        r_err  <= '0;
                        r_widx <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    // Counting continues through drops so the trailer
                    // position stays aligned with the stream.
                    r_widx <= r_widx + WW'(1);
                    if (w_drop) r_err[1] <= 1'b1;
                    if (w_widx_end && !w_single) begin
                        r_roi <= r_roi & ~(ROI_W'(1) << w_pix);
                    end
                end
                ST_TRAILER: begin
                    r_done      <= 1'b1;
                    r_frame_err <= w_trl_err;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                    if ((w_trl_err != 2'b00) && (r_err_cnt != 8'hFF)) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Outputs; payload fields are forced to 0 while the FIFO is empty.
    // ---------------------------------------------------------------
    assign bus.rd_valid   = ~w_empty;
    assign bus.rd_data    = w_empty ? '0   : w_head.data;
    assign bus.rd_pix     = w_empty ? '0   : w_head.pix;
    assign bus.rd_widx    = w_empty ? '0   : w_head.widx;
    assign bus.rd_last    = w_empty ? 1'b0 : w_head.last;
    assign bus.frame_l1id = r_l1id;
    assign bus.frame_done = r_done;
    assign bus.frame_err  = r_frame_err;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.frame_cnt  = r_frame_cnt;
    assign bus.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_frame_decoder.sv
// Self-checking bench for frame_decoder: directed frames from the test plan
// plus randomized frames, all compared against a queue-based frame model.
module tb_frame_decoder;

    localparam int DEPTH = 16;

    logic clock = 1'b0;
    logic reset;

    always #12 clock = ~clock;

    frame_decoder_if bus();

    frame_decoder #(
        .FIFO_DEPTH           (DEPTH),
        .WORDS_PER_PIXEL_LOG2 (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [42:0] m_fifo[$];   // {last, pix, widx, data} awaiting delivery
    logic [11:0] m_tags[$];   // {pix, widx} still expected in this frame
    bit          m_in_frame;
    bit          m_ovf;
    bit          m_done;
    logic [1:0]  m_err_out;
    int          m_frame_cnt;
    int          m_err_cnt;
    logic [11:0] m_l1id;

    logic [15:0] t_roi;
    int          n_pops;

    task automatic model_reset();
        m_fifo.delete();
        m_tags.delete();
        m_in_frame  = 0;
        m_ovf       = 0;
        m_done      = 0;
        m_err_out   = 2'b00;
        m_frame_cnt = 0;
        m_err_cnt   = 0;
        m_l1id      = 12'h0;
    endtask

    task automatic model_step(input logic [29:0] w, input logic rdy,
                              input logic [15:0] roi_v);
        logic [11:0] tg;
        m_done = 0;
        if (rdy && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (!m_in_frame) begin
            if (w[29:12] == 18'h25555) begin
                m_in_frame = 1;
                m_l1id     = w[11:0];
                m_ovf      = 0;
                m_tags.delete();
                for (int p = 15; p >= 0; p--)
                    if (roi_v[p])
                        for (int k = 0; k < 256; k++)
                            m_tags.push_back({4'(p), 8'(k)});
            end
        end else if (m_tags.size() > 0) begin
            tg = m_tags.pop_front();
            if (m_fifo.size() < DEPTH) m_fifo.push_back({m_tags.size() == 0, tg, w});
            else m_ovf = 1;
        end else begin
            m_in_frame  = 0;
            m_done      = 1;
            m_err_out   = {m_ovf, w != 30'h2EADBEEF};
            m_frame_cnt = m_frame_cnt + 1;
            if (m_err_out != 2'b00 && m_err_cnt < 255) m_err_cnt = m_err_cnt + 1;
        end
    endtask

    task automatic check_outputs();
        check_val("rd_valid", bus.rd_valid, m_fifo.size() > 0);
        if (m_fifo.size() > 0)
            check_val("rd_word", {bus.rd_last, bus.rd_pix, bus.rd_widx, bus.rd_data}, m_fifo[0]);
        check_val("frame_done", bus.frame_done, m_done);
        if (m_done) check_val("frame_err", bus.frame_err, m_err_out);
        check_val("frame_cnt", bus.frame_cnt, 16'(m_frame_cnt));
        check_val("err_cnt", bus.err_cnt, m_err_cnt);
        check_val("busy", bus.busy, m_in_frame);
        check_val("frame_l1id", bus.frame_l1id, m_l1id);
    endtask

    // One stream word per clock; entered and left at a falling edge.
    task automatic cyc(input logic [29:0] w, input logic rdy);
        check_outputs();
        if (bus.rd_valid && rdy) n_pops++;
        bus.din      = w;
        bus.rd_ready = rdy;
        bus.roi      = t_roi;
        @(posedge clock);
        model_step(w, rdy, t_roi);
        @(negedge clock);
    endtask

    function automatic logic pick(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic idle_cycles(input int n, input int pct);
        for (int i = 0; i < n; i++) cyc(30'h0, pick(pct));
    endtask

    task automatic send_frame(input logic [11:0] bcid, input logic [15:0] roi_v,
                              input int pct, input logic [29:0] trl,
                              input bit idx_data, input int alias_idx,
                              input int stop_at);
        int n;
        logic [29:0] w;
        t_roi = roi_v;
        n = 256 * $countones(roi_v);
        cyc({18'h25555, bcid}, pick(pct));
        for (int i = 0; i < n; i++) begin
            if (i == stop_at) return;
            w = idx_data ? 30'(i) : 30'($urandom);
            if (i == alias_idx) w = 30'h2EADBEEF;
            cyc(w, pick(pct));
        end
        cyc(trl, pick(pct));
    endtask

    initial begin
        logic [15:0] rr;
        logic [29:0] trl;
        reset        = 1'b1;
        bus.din      = 30'h0;
        bus.roi      = 16'h0;
        bus.rd_ready = 1'b0;
        t_roi        = 16'h0;
        n_pops       = 0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check_val("rst_rd_valid", bus.rd_valid, 0);
        check_val("rst_rd_data", bus.rd_data, 0);
        check_val("rst_rd_last", bus.rd_last, 0);
        check_val("rst_frame_done", bus.frame_done, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_frame_cnt", bus.frame_cnt, 0);
        check_val("rst_err_cnt", bus.err_cnt, 0);
        check_val("rst_l1id", bus.frame_l1id, 0);
        reset = 1'b0;

        // Empty-ROI frame preceded by idle words.
        idle_cycles(2, 100);
        send_frame(12'h123, 16'h0000, 100, 30'h2EADBEEF, 1, -1, -1);
        check_val("tp1_l1id", bus.frame_l1id, 12'h123);
        idle_cycles(2, 100);
        check_val("tp1_frame_cnt", bus.frame_cnt, 1);

        // Single pixel, index data.
        send_frame(12'h0A5, 16'h0001, 100, 30'h2EADBEEF, 1, -1, -1);
        idle_cycles(3, 100);

        // Four pixels, payload word 10 aliases EOF.
        send_frame(12'hFFF, 16'h9201, 100, 30'h2EADBEEF, 0, 10, -1);
        idle_cycles(3, 100);

        // Bad trailer, then a clean frame.
        send_frame(12'h456, 16'h0001, 100, 30'h0, 1, -1, -1);
        idle_cycles(1, 100);
        check_val("tp4_err_cnt", bus.err_cnt, 1);
        send_frame(12'h789, 16'h0001, 100, 30'h2EADBEEF, 1, -1, -1);
        idle_cycles(2, 100);

        // Overflow with no drain, then drain exactly one FIFO's worth.
        send_frame(12'h321, 16'h0001, 0, 30'h2EADBEEF, 1, -1, -1);
        idle_cycles(2, 0);
        n_pops = 0;
        idle_cycles(DEPTH + 8, 100);
        check_val("ovf_drain", n_pops, DEPTH);

        // SOF-looking trailer word must not open a new frame.
        send_frame(12'h111, 16'h0000, 100, {18'h25555, 12'h222}, 1, -1, -1);
        idle_cycles(3, 100);
        check_val("sof_trl_busy", bus.busy, 0);

        // Reset in the middle of payload word 100.
        send_frame(12'h0BC, 16'h0001, 100, 30'h2EADBEEF, 1, -1, 100);
        check_outputs();
        reset = 1'b1;
        #1;
        check_val("mid_rst_rd_valid", bus.rd_valid, 0);
        check_val("mid_rst_busy", bus.busy, 0);
        check_val("mid_rst_frame_cnt", bus.frame_cnt, 0);
        check_val("mid_rst_done", bus.frame_done, 0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        send_frame(12'hABC, 16'h8001, 70, 30'h2EADBEEF, 0, -1, -1);
        idle_cycles(DEPTH + 4, 100);

        // Randomized frames.
        for (int f = 0; f < 12; f++) begin
            rr  = 16'($urandom & $urandom & $urandom);
            trl = pick(80) ? 30'h2EADBEEF : 30'($urandom);
            case ($urandom_range(3))
                0:       send_frame(12'($urandom), rr, 100, trl, 0, -1, -1);
                1:       send_frame(12'($urandom), rr, 90, trl, 0, -1, -1);
                2:       send_frame(12'($urandom), rr, 60, trl, 0, $urandom_range(255), -1);
                default: send_frame(12'($urandom), rr, 100, trl, 1, -1, -1);
            endcase
            for (int g = $urandom_range(5); g > 0; g--)
                cyc(pick(20) ? 30'h2EADBEEF : 30'($urandom_range(1023)), pick(80));
        end
        idle_cycles(DEPTH + 4, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_decoder.md
Name: frame_decoder

Overview:
- Receive-side counterpart of the ETROC1 4x4 readout sequencer.
- Samples the 30-bit parallel readout stream one word per clock, locks onto the start-of-frame word and extracts its L1ACC/BCID.
- Delivers each payload word tagged with pixel index and word index into a small FIFO with a valid/ready interface.
- Checks the end-of-frame trailer and frame length. Used in the FPGA test firmware and testbenches to reconstruct events.

Parameters:
- FIFO_DEPTH, 16, payload FIFO entries (power of 2, >=4).
- WORDS_PER_PIXEL_LOG2, 8, log2 of words per pixel buffer (256 words).

Ports:
- clock  in  1  system clock, 40 MHz, one stream word per rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- din  in  30  readout stream from the sequencer/serializer.
- roi  in  16  region-of-interest mask; must match the sequencer; latched at SOF.
- rd_ready  in  1  downstream accepts the FIFO head.
- rd_valid  out  1  FIFO head valid.
- rd_data  out  30  payload word.
- rd_pix  out  4  pixel index (0..15) of rd_data.
- rd_widx  out  8  word index within the pixel buffer.
- rd_last  out  1  last payload word of the frame.
- frame_l1id  out  12  L1ACC BCID from the most recent SOF.
- frame_done  out  1  one-cycle pulse when a frame ends (good or bad).
- frame_err  out  2  valid with frame_done. Bit0 = bad trailer, bit1 = FIFO overflow.
- busy  out  1  high while not in IDLE.
- frame_cnt  out  16  frames completed, wraps.
- err_cnt  out  8  frames with any error, saturates at 255.

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE.
- Constants:
  - SOF when din[29:12] == 18'h25555; din[11:0] is the BCID.
  - EOF when din == 30'h2EADBEEF.
  - Idle word is 30'h0.
- States: IDLE, PAYLOAD, TRAILER.
- IDLE:
  - On SOF: latch frame_l1id <= din[11:0], roi_reg <= roi, clear the per-frame error sticky, set word counter to 0, busy = 1.
  - If roi == 0, go to TRAILER; otherwise go to PAYLOAD.
  - All non-SOF words, including EOF, are ignored.
- PAYLOAD:
  - Every cycle accepts one word; no pattern matching on payload (data may alias SOF/EOF).
  - Current pixel is the index of the highest set bit of roi_reg (priority encoder, same peel order as the sequencer).
  - Push {last, pix, widx, din} to the FIFO.
  - At widx == 255:
    - If roi_reg has exactly one bit set, mark last and go to TRAILER.
    - Otherwise clear the highest set bit of roi_reg, set widx to 0, and stay in PAYLOAD.
  - Frame length is 256 × popcount(roi).
- TRAILER:
  - The next word must be EOF; otherwise set bit0 of the error.
  - Always return to IDLE; that word is not re-examined as SOF.
  - Pulse frame_done with frame_err = sticky flags.
  - frame_cnt increments; err_cnt increments (saturating) if frame_err != 0.
- Latency:
  - Word sampled at edge N appears at the FIFO output at the earliest at N+1 (rd_valid high after edge N).
  - frame_done is high for the cycle after the edge that sampled the trailer word.
- FIFO:
  - Standard first-word-fall-through; pop on rd_valid & rd_ready.
  - Simultaneous push and pop when full is allowed (no overflow).
  - Push when full and no pop: the word is dropped and overflow sticky bit1 is set. The decoder keeps counting so frame alignment holds.
  - If the dropped word carried last, no rd_last is emitted for that frame.
- Reset mid-frame: immediate return to IDLE; FIFO flushed; counters cleared; no frame_done.

Decomposition:
- Shared package (readout_pkg) holds:
  - SOF_MARK = 18'h25555, EOF_WORD = 30'h2EADBEEF, IDLE_WORD = 0.
  - Widths: DATA_W = 30, BCID_W = 12, ROI_W = 16.
  - State enum.
- The priority-encoder function is shared with the sequencer.
- One sub-module: frame_fifo, a synchronous FWFT FIFO with full/empty flags and simultaneous push/pop support.

Test Plan:
- roi=0, stream 0, 0, {18'h25555,12'h123}, 30'h2EADBEEF -> frame_done with frame_err=0, frame_l1id=12'h123, no rd_valid, frame_cnt=1.
- roi=16'h0001, SOF, 256 words 0..255, EOF, rd_ready=1 -> 256 outputs with rd_pix=0, rd_widx=0..255, rd_last only on word 255, frame_err=0.
- roi=16'h9201, 1024 payload words (including one equal to 30'h2EADBEEF at word 10), EOF -> pixels in order 15, 12, 9, 0, 256 words each; the aliased word is passed as data; frame_err=0.
- roi=16'h0001, SOF, 256 words, then 30'h0 instead of EOF -> frame_done with frame_err=2'b01, err_cnt=1; the next SOF is decoded normally.
- rd_ready=0, roi=16'h0001 frame -> first 16 words kept, rest dropped, frame_err=2'b10; raising rd_ready drains exactly 16 words with rd_widx 0..15.
- reset asserted mid-payload at word 100 -> rd_valid=0, busy=0, frame_cnt=0 immediately; a subsequent full frame decodes cleanly.
